// File: rtl/vroom_axi_pkg.sv
// Shared AXI constants and the scan-out DMA state encoding.
package vroom_axi_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty gates rd_data so stale words never leak out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/frmbuf_scanout_dma.sv
// AXI4 read burst master that streams a linear framebuffer into a FWFT FIFO
// feeding the pixel stage; frame_start drains any open burst and restarts at BASE_ADDR.
module frmbuf_scanout_dma
  import vroom_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hC000_0000,
  parameter int          FRAME_WORDS = 196608,
  parameter int          BURST_LEN   = 16,
  parameter int          FIFO_DEPTH  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic        m_axi_rlast,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [31:0] pix_data,
  output logic        underflow,
  output logic        rd_err
);

  localparam int OFF_W = $clog2(FRAME_WORDS) + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  dma_state_e       state_q, state_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             pend_q, pend_d;
  logic             underflow_q, underflow_d;
  logic             rd_err_q, rd_err_d;

  logic             fifo_flush, fifo_push, fifo_pop;
  logic             fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] free_slots;
  logic             room, beat;
  logic [OFF_W-1:0] off_inc, off_next;

  assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign room       = (free_slots >= CNT_W'(BURST_LEN));
  assign beat       = m_axi_rvalid && m_axi_rready;
  assign off_inc    = offset_q + OFF_W'(BURST_LEN);
  assign off_next   = (off_inc >= OFF_W'(FRAME_WORDS)) ? '0 : off_inc;

  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? (BASE_ADDR + (32'(offset_q) << 2)) : '0;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_rready  = (state_q == DATA) || (state_q == DRAIN);

  assign fifo_push = beat && (state_q == DATA) && !fifo_full;
  assign fifo_pop  = pix_ready;
  assign pix_valid = !fifo_empty;
  assign underflow = underflow_q;
  assign rd_err    = rd_err_q;

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    pend_d     = pend_q;
    fifo_flush = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          offset_d   = '0;
          fifo_flush = 1'b1;
        end
        // After a flush the whole FIFO is free, so frame_start also satisfies the room check.
        if (enable && (frame_start || room)) state_d = ADDR;
      end
      ADDR: begin
        if (m_axi_arready) begin
          state_d = (pend_q || frame_start) ? DRAIN : DATA;
          pend_d  = 1'b0;
        end else if (frame_start) begin
          pend_d = 1'b1;
        end
      end
      DATA: begin
        if (beat && m_axi_rlast) begin
          state_d = IDLE;
          if (frame_start) begin
            offset_d   = '0;
            fifo_flush = 1'b1;
          end else begin
            offset_d = off_next;
          end
        end else if (frame_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (beat && m_axi_rlast) begin
          state_d    = IDLE;
          offset_d   = '0;
          fifo_flush = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    underflow_d = underflow_q | (pix_ready & fifo_empty & enable);
    rd_err_d    = rd_err_q | (beat & (m_axi_rresp != AXI_RESP_OKAY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      pend_q      <= 1'b0;
      underflow_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      pend_q      <= pend_d;
      underflow_q <= underflow_d;
      rd_err_q    <= rd_err_d;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data (m_axi_rdata),
    .pop     (fifo_pop),
    .rd_data (pix_data),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule
